// File: rtl/apb_bcd_requester.sv
// APB requester that runs one BCD addition on the APB_BCD completer: writes operands and start,
// polls for done, reads the sum. Optional build macro: BCD_INPUT_CHECK_EN (rejects non-BCD operands).
module apb_bcd_requester #(
  parameter int unsigned DIGITS    = 3,
  parameter logic [31:0] ADDR_CTRL = 32'h0,
  parameter logic [31:0] ADDR_A    = 32'h4,
  parameter logic [31:0] ADDR_B    = 32'h8,
  parameter logic [31:0] ADDR_RES  = 32'hC,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4*DIGITS-1:0]     op_a,
  input  logic [4*DIGITS-1:0]     op_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*(DIGITS+1)-1:0] res_data,
  output logic                    res_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY
);

  localparam int unsigned OpW  = 4 * DIGITS;
  localparam int unsigned ResW = 4 * (DIGITS + 1);
  localparam int unsigned CntW = $clog2(POLL_MAX + 1);
  localparam logic [CntW-1:0] PollLast = CntW'(POLL_MAX - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;
  typedef enum logic [2:0] {StepWrA, StepWrB, StepWrCtrl, StepPoll, StepRdRes} step_e;

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [OpW-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]     paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ResW-1:0] res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            reject;

`ifdef BCD_INPUT_CHECK_EN
  function automatic logic has_bad_nibble(input logic [OpW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign reject = has_bad_nibble(op_a) | has_bad_nibble(op_b);
`else
  assign reject = 1'b0;
`endif

  logic unused_prdata;
  assign unused_prdata = ^{PRDATA[31:ResW], PRDATA[0]};

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_a_d = op_a;
          op_b_d = op_b;
          cnt_d  = '0;
          if (reject) begin
            state_d    = StResp;
            res_err_d  = 1'b1;
            res_data_d = '0;
          end else begin
            state_d = StSetup;
            step_d  = StepWrA;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (PREADY) begin
          state_d = StSetup;
          unique case (step_q)
            StepWrA:    step_d = StepWrB;
            StepWrB:    step_d = StepWrCtrl;
            StepWrCtrl: step_d = StepPoll;
            StepPoll: begin
              if (PRDATA[1]) begin
                step_d = StepRdRes;
              end else if (cnt_q == PollLast) begin
                state_d    = StResp;
                res_err_d  = 1'b1;
                res_data_d = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            StepRdRes: begin
              state_d    = StResp;
              res_data_d = PRDATA[ResW-1:0];
              res_err_d  = 1'b0;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StResp: if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Address/data are loaded once on entry to SETUP and held through ACCESS and afterwards.
    if (state_d == StSetup) begin
      unique case (step_d)
        StepWrA: begin
          paddr_d = ADDR_A; pwdata_d = 32'(op_a_d); pwrite_d = 1'b1;
        end
        StepWrB: begin
          paddr_d = ADDR_B; pwdata_d = 32'(op_b_d); pwrite_d = 1'b1;
        end
        StepWrCtrl: begin
          paddr_d = ADDR_CTRL; pwdata_d = 32'h1; pwrite_d = 1'b1;
        end
        StepPoll: begin
          paddr_d = ADDR_CTRL; pwdata_d = 32'h0; pwrite_d = 1'b0;
        end
        StepRdRes: begin
          paddr_d = ADDR_RES; pwdata_d = 32'h0; pwrite_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StIdle;
      step_q     <= StepWrA;
      op_a_q     <= '0;
      op_b_q     <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign PSEL      = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE   = (state_q == StAccess);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign res_valid = (state_q == StResp);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_apb_bcd_requester.sv
// Bench for apb_bcd_requester: behavioural APB BCD completer, transfer scoreboard and
// table-driven requests, plus hand sequences for reset and (BCD_INPUT_CHECK_EN) input rejection.
module tb_apb_bcd_requester;

  logic        PCLK, PRESET;
  logic        req_valid, req_ready, res_valid, res_ready, res_err;
  logic [11:0] op_a, op_b;
  logic [15:0] res_data;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  apb_bcd_requester dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    int          wait_b;
    int          done_after;
    int          hold;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic        bad;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } xfer_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } resp_t;

  xfer_t exp_q[$];
  resp_t resp_q[$];
  vec_t  vecs[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Completer state
  int          wait_b = 0, wait_ctrl = 0, done_after = 1, poll_idx = 0;
  int          acc = 0, need = 0, setups = 0;
  logic        stable;
  logic [31:0] s_addr, s_wdata, ra, rb, r;
  logic        s_wr;

  function automatic logic [15:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [15:0] s;
    logic [4:0]  d;
    logic        c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = d[3:0];
    end
    s[15:12] = {3'b000, c};
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task complete_xfer();
    xfer_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL apb_xfer: unexpected wr=%0b addr=%h data=%h", s_wr, s_addr, s_wdata);
    end else begin
      e = exp_q.pop_front();
      if (s_wr !== e.wr || s_addr !== e.addr || s_wdata !== e.data || acc != e.acc || !stable) begin
        n_fail++;
        $display("FAIL apb_xfer: got wr=%0b addr=%h data=%h acc=%0d stable=%0b expected wr=%0b addr=%h data=%h acc=%0d stable=1",
                 s_wr, s_addr, s_wdata, acc, stable, e.wr, e.addr, e.data, e.acc);
      end
    end
    r = $urandom;
    PRDATA = r;
    if (s_wr) begin
      if (s_addr == 32'h4) ra = s_wdata;
      if (s_addr == 32'h8) rb = s_wdata;
      if (s_addr == 32'h0 && s_wdata[0]) poll_idx = 0;
    end else if (s_addr == 32'h0) begin
      poll_idx++;
      PRDATA = (r & ~32'h2) | ((poll_idx >= done_after) ? 32'h2 : 32'h0);
    end else if (s_addr == 32'hC) begin
      PRDATA = {r[15:0], bcd_add(ra[11:0], rb[11:0])};
    end
  endtask

  // PREADY and PRDATA are driven at negedge for the following rising edge.
  always @(negedge PCLK) begin
    if (PRESET) begin
      acc    = 0;
      PREADY = 1'b1;
      PRDATA = '0;
    end else if (PSEL && !PENABLE) begin
      setups++;
      s_addr  = PADDR;
      s_wdata = PWDATA;
      s_wr    = PWRITE;
      acc     = 0;
      stable  = 1'b1;
      PREADY  = 1'b1;  // ignored outside ACCESS
    end else if (PSEL && PENABLE) begin
      acc++;
      if (PADDR !== s_addr || PWDATA !== s_wdata || PWRITE !== s_wr) stable = 1'b0;
      need = (s_wr && s_addr == 32'h8) ? wait_b : (s_wr && s_addr == 32'h0) ? wait_ctrl : 0;
      if (acc <= need) begin
        PREADY = 1'b0;
        r = $urandom;
        PRDATA = r;
      end else begin
        PREADY = 1'b1;
        complete_xfer();
      end
    end else begin
      PREADY = 1'b1;
      r = $urandom;
      PRDATA = r;
    end
  end

  task automatic push_seq(input vec_t v);
    int   polls;
    logic tmo;
    if (v.bad) return;
    tmo   = v.done_after > 16;
    polls = tmo ? 16 : v.done_after;
    exp_q.push_back('{1'b1, 32'h4, 32'(v.a), 1});
    exp_q.push_back('{1'b1, 32'h8, 32'(v.b), 1 + v.wait_b});
    exp_q.push_back('{1'b1, 32'h0, 32'h1, 1});
    for (int i = 0; i < polls; i++) exp_q.push_back('{1'b0, 32'h0, 32'h0, 1});
    if (!tmo) exp_q.push_back('{1'b0, 32'hC, 32'h0, 1});
  endtask

  task automatic do_req(input vec_t v);
    int    lat;
    resp_t e;
    wait_b     = v.wait_b;
    done_after = v.done_after;
    push_seq(v);
    resp_q.push_back('{v.exp_data, v.exp_err});
    @(negedge PCLK);
    op_a = v.a;
    op_b = v.b;
    req_valid = 1'b1;
    check("req_ready_idle", 64'(req_ready), 64'(1));
    @(negedge PCLK);
    req_valid = 1'b0;
    op_a = 12'hFFF;
    op_b = 12'hFFF;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge PCLK);
      lat++;
    end
    check("res_latency", 64'(lat), 64'(v.exp_lat));
    e = resp_q.pop_front();
    for (int h = 0; h < v.hold; h++) begin
      check("hold_stable", 64'({res_valid, req_ready, PSEL, PENABLE, res_err, res_data}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, e.err, e.data}));
      req_valid = 1'b1;
      op_a = 12'h321;
      op_b = 12'h123;
      @(negedge PCLK);
    end
    check("res_data", 64'(res_data), 64'(e.data));
    check("res_err", 64'({res_valid, res_err}), 64'({1'b1, e.err}));
    res_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge PCLK);
    res_ready = 1'b0;
    check("res_done", 64'({res_valid, req_ready}), 64'(2'b01));
    check("xfer_q_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    int   n;
    int   s0;
    vecs[0] = '{12'h886, 12'h693, 0, 1,    0, 16'h1579, 1'b0, 11, 1'b0};
    vecs[1] = '{12'h999, 12'h001, 0, 1,    0, 16'h1000, 1'b0, 11, 1'b0};
    vecs[2] = '{12'h000, 12'h000, 0, 1,    0, 16'h0000, 1'b0, 11, 1'b0};
    vecs[3] = '{12'h999, 12'h999, 0, 1,    0, 16'h1998, 1'b0, 11, 1'b0};
    vecs[4] = '{12'h123, 12'h456, 3, 1,    0, 16'h0579, 1'b0, 14, 1'b0};
    vecs[5] = '{12'h250, 12'h750, 0, 4,    0, 16'h1000, 1'b0, 17, 1'b0};
    vecs[6] = '{12'h111, 12'h222, 0, 1000, 0, 16'h0000, 1'b1, 39, 1'b0};
    vecs[7] = '{12'h045, 12'h055, 0, 1,    5, 16'h0100, 1'b0, 11, 1'b0};

    PRESET = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    PREADY = 1'b1;
    PRDATA = '0;
    ra = '0;
    rb = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("reset_ctl", 64'({PSEL, PENABLE, PWRITE, res_valid, res_err}), 64'(0));
    check("reset_paddr", 64'(PADDR), 64'(0));
    check("reset_pwdata", 64'(PWDATA), 64'(0));
    check("reset_res_data", 64'(res_data), 64'(0));
    PRESET = 1'b0;

    for (int i = 0; i < 8; i++) do_req(vecs[i]);

    // Reset pulsed while WR_CTRL is stretched in ACCESS.
    wait_b = 0;
    wait_ctrl = 5;
    done_after = 1;
    exp_q.push_back('{1'b1, 32'h4, 32'h886, 1});
    exp_q.push_back('{1'b1, 32'h8, 32'h693, 1});
    exp_q.push_back('{1'b1, 32'h0, 32'h1, 6});
    @(negedge PCLK);
    op_a = 12'h886;
    op_b = 12'h693;
    req_valid = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0;
    n = 0;
    while (!(PSEL && PENABLE && PWRITE && PADDR == 32'h0) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("wr_ctrl_access", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'({3'b111, 32'h0}));
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    check("mid_reset_ctl", 64'({PSEL, PENABLE, PWRITE, res_valid, res_err}), 64'(0));
    check("mid_reset_paddr", 64'(PADDR), 64'(0));
    check("mid_reset_pwdata", 64'(PWDATA), 64'(0));
    check("mid_reset_res_data", 64'(res_data), 64'(0));
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_ctrl = 0;
    check("pending_after_reset", 64'(exp_q.size()), 64'(1));
    exp_q.delete();
    do_req(vecs[0]);

`ifdef BCD_INPUT_CHECK_EN
    s0 = setups;
    v = '{12'h8A6, 12'h123, 0, 1, 0, 16'h0000, 1'b1, 1, 1'b1};
    do_req(v);
    v = '{12'h123, 12'h90F, 0, 1, 0, 16'h0000, 1'b1, 1, 1'b1};
    do_req(v);
    check("no_psel_bad_bcd", 64'(setups - s0), 64'(0));
    do_req(vecs[3]);
`else
    s0 = setups;
    v = vecs[1];
    do_req(v);
    check("setups_per_req", 64'(setups - s0), 64'(5));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_bcd_requester.md
Name: apb_bcd_requester

Overview:
- Autonomous APB requester that runs one complete BCD addition on the APB_BCD completer.
- Accepts two packed-BCD operands on a valid/ready request port.
- Issues APB writes for operand A, operand B and control, polls control for done, reads the result, and returns it on a valid/ready response port.
- Replaces hand-sequenced APB_master stimulus; sits between a local controller and the APB bus of the BCD peripheral.

Parameters:
- DIGITS, 3: BCD digits per operand; operand width 4*DIGITS.
- ADDR_CTRL, 32'h0: control register; write bit0=1 starts; read bit1=done.
- ADDR_A, 32'h4: operand A register.
- ADDR_B, 32'h8: operand B register.
- ADDR_RES, 32'hC: result register; low 4*(DIGITS+1) bits are the sum, carry digit on top.
- POLL_MAX, 16: maximum control reads before timeout.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE.
- op_a  in  4*DIGITS  packed BCD operand A.
- op_b  in  4*DIGITS  packed BCD operand B.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  4*(DIGITS+1)  BCD sum.
- res_err  out  1  error flag, qualified by res_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  1=write, 0=read.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  completer ready.

Behaviour:
- Reset, asynchronous, any state: state=IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - res_valid, res_err, res_data = 0; poll counter = 0.
  - Any in-flight APB transfer is abandoned, with no completion.
- IDLE: req_ready=1. On req_valid&req_ready, capture op_a/op_b into internal registers and set step=WR_A. Ports are not sampled again until IDLE.
- Step sequence:
  - WR_A: write op_a zero-extended to ADDR_A.
  - WR_B: write op_b zero-extended to ADDR_B.
  - WR_CTRL: write 32'h1 to ADDR_CTRL.
  - POLL: read ADDR_CTRL.
  - RD_RES: read ADDR_RES.
  - RESP.
- Each transfer uses two phases:
  - SETUP, exactly 1 cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid.
  - ACCESS: PSEL=1, PENABLE=1, all outputs held stable. Stay while PREADY=0. On PREADY=1, complete and sample PRDATA for reads.
- Between transfers: next step's SETUP follows directly. PSEL stays 1; PENABLE drops for 1 cycle.
- POLL handling:
  - If PRDATA[1]=1, go to RD_RES.
  - Else increment the poll counter and repeat POLL.
  - When the counter reaches POLL_MAX with done still 0, go to RESP with res_err=1, res_data=0, skipping RD_RES.
- RD_RES: res_data = PRDATA[4*(DIGITS+1)-1:0]; res_err=0.
- RESP:
  - PSEL=0, PENABLE=0.
  - res_valid=1; hold res_data/res_err until res_ready=1.
  - On that cycle, clear res_valid and return to IDLE.
  - req_ready rises the next cycle; back-to-back requests are never accepted during RESP.
- Latency, zero-wait completer, done on first poll: 10 APB cycles from the acceptance cycle to res_valid, plus 1.
- PWDATA is 0 during reads. PADDR retains its last value while PSEL=0.
- PREADY outside ACCESS is ignored.

Optional Feature:
- BCD_INPUT_CHECK_EN defined:
  - At acceptance, any op_a/op_b nibble greater than 9 issues no APB traffic.
  - Goes straight to RESP with res_err=1, res_data=0.
- Undefined: operands are forwarded unchecked; res_err asserts only on poll timeout.

Test Plan:
- op_a=12'h886, op_b=12'h693, zero-wait completer -> APB writes 0x4=0x886, 0x8=0x693, 0x0=0x1, reads 0x0 then 0xC; res_data=16'h1579, res_err=0, res_valid 11 cycles after acceptance.
- Completer inserts 3 wait states on the WR_B ACCESS -> PADDR/PWDATA/PENABLE stable for 4 cycles; final res_data unchanged.
- Done bit set only on the 4th poll -> exactly 4 reads of 0x0 before 0xC; result correct.
- Done never set, POLL_MAX=16 -> 16 reads of 0x0, no read of 0xC; res_err=1, res_data=0.
- res_ready held low 5 cycles -> res_valid and res_data stable; req_ready=0 throughout; idle APB bus.
- PRESET pulsed mid-ACCESS of WR_CTRL -> all outputs 0 that cycle; the next request runs the full sequence from WR_A.
- With BCD_INPUT_CHECK_EN: op_a=12'h8A6 -> no PSEL; res_err=1 on the RESP cycle.
